// File: rtl/mux7seg_scan_if.sv
// mux7seg_scan_if: control inputs and display outputs of the 7-segment scanner
interface mux7seg_scan_if;
  logic en;
  logic load;
  logic [15:0] data;
  logic [3:0] bcd;
  logic den;
  logic [3:0] an;
  logic tick;
  modport master(output en, load, data, input bcd, den, an, tick);
  modport slave(input en, load, data, output bcd, den, an, tick);
endinterface

// File: rtl/mux7seg_scan.sv
// mux7seg_scan: 4-digit multiplexed common-anode scanner; LZ_BLANK_EN blanks leading zeros
module mux7seg_scan #(
  parameter int DIV = 50000,
  parameter int GAP = 16
) (
  input logic clk,
  input logic rst,
  mux7seg_scan_if.slave io
);
  localparam int PW_D = DIV > 1 ? $clog2(DIV) : 1;
  localparam int PW_G = GAP > 1 ? $clog2(GAP) : 1;
  localparam int PW = PW_D > PW_G ? PW_D : PW_G;
  localparam logic [PW-1:0] DLAST = PW'(DIV - 1);
  localparam logic [PW-1:0] GLAST = PW'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n;
  logic [PW-1:0] cnt, cnt_n;
  logic [15:0] shadow, frame, frame_n;
  logic [3:0] an_r, an_n, bcd_r, bcd_n;
  logic den_r, den_n, tick_r, wrap, fstart, lit;
  always_comb begin
    state_n = state;
    idx_n = idx;
    cnt_n = cnt + 1'b1;
    wrap = 1'b0;
    fstart = 1'b0;
    if (!io.en) begin
      state_n = S_IDLE;
      idx_n = 2'd0;
      cnt_n = '0;
    end else if (state == S_IDLE) begin
      state_n = S_SHOW;
      idx_n = 2'd0;
      cnt_n = '0;
      fstart = 1'b1;
    end else if (state == S_SHOW && cnt == DLAST) begin
      cnt_n = '0;
      if (GAP == 0) begin
        idx_n = idx + 2'd1;
        wrap = idx == 2'd3;
        fstart = wrap;
      end else begin
        state_n = S_GAP;
      end
    end else if (state == S_GAP && cnt == GLAST) begin
      state_n = S_SHOW;
      cnt_n = '0;
      idx_n = idx + 2'd1;
      wrap = idx == 2'd3;
      fstart = wrap;
    end
    frame_n = fstart ? (io.load ? io.data : shadow) : frame;
`ifdef LZ_BLANK_EN
    lit = idx_n == 2'd0 || (frame_n >> {idx_n, 2'b00}) != 16'h0;
`else
    lit = 1'b1;
`endif
    den_n = state_n == S_SHOW && lit;
    an_n = den_n ? ~(4'b0001 << idx_n) : 4'hf;
    bcd_n = state_n == S_SHOW ? frame_n[{idx_n, 2'b00} +: 4] : bcd_r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx <= 2'd0;
      cnt <= '0;
      shadow <= 16'h0;
      frame <= 16'h0;
      an_r <= 4'hf;
      bcd_r <= 4'h0;
      den_r <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cnt <= cnt_n;
      shadow <= io.load ? io.data : shadow;
      frame <= frame_n;
      an_r <= an_n;
      bcd_r <= bcd_n;
      den_r <= den_n;
      tick_r <= wrap;
    end
  end
  assign io.an = an_r;
  assign io.bcd = bcd_r;
  assign io.den = den_r;
  assign io.tick = tick_r;
endmodule

// File: tb/tb_mux7seg_scan.sv
// tb_mux7seg_scan: scoreboard bench; the model derives outputs from elapsed scan time
module tb_mux7seg_scan;
  localparam int DIV = 4, GAP = 1, SEG = DIV + GAP, PER = 4 * SEG;
  logic clk = 1'b0;
  logic rst;
  mux7seg_scan_if io();
  mux7seg_scan #(.DIV(DIV), .GAP(GAP)) dut (.clk(clk), .rst(rst), .io(io));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bcd;
    logic den;
    logic tick;
  } exp_t;
  exp_t q[$];
  int nchk = 0, nfail = 0, k = -1;
  logic [15:0] msh = 16'h0, mfr = 16'h0;
  logic [3:0] mbcd = 4'h0;
  // k counts cycles since the scan started; -1 means the display is idle
  task automatic step(input logic r, input logic e, input logic l, input logic [15:0] d);
    exp_t x;
    int p, dg;
    logic lit;
    @(negedge clk);
    rst = r;
    io.en = e;
    io.load = l;
    io.data = d;
    @(posedge clk);
    x.an = 4'hf;
    x.den = 1'b0;
    x.tick = 1'b0;
    if (r) begin
      msh = 16'h0;
      mfr = 16'h0;
      mbcd = 4'h0;
      k = -1;
    end else begin
      if (!e) k = -1;
      else begin
        k++;
        p = k % PER;
        dg = p / SEG;
        if (p == 0) begin
          mfr = l ? d : msh;
          x.tick = k > 0;
        end
        if (p % SEG < DIV) begin
          mbcd = mfr[4*dg +: 4];
`ifdef LZ_BLANK_EN
          lit = dg == 0 || (mfr >> (4 * dg)) != 16'h0;
`else
          lit = 1'b1;
`endif
          if (lit) begin
            x.an = ~(4'b0001 << dg);
            x.den = 1'b1;
          end
        end
      end
      if (l) msh = d;
    end
    x.bcd = mbcd;
    q.push_back(x);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      nchk++;
      if ({io.an, io.bcd, io.den, io.tick} !== e) begin
        nfail++;
        $display("FAIL out t=%0t: an=%b bcd=%h den=%b tick=%b, expected an=%b bcd=%h den=%b tick=%b",
                 $time, io.an, io.bcd, io.den, io.tick, e.an, e.bcd, e.den, e.tick);
      end
    end
  end
  initial begin
    rst = 1'b1;
    io.en = 1'b0;
    io.load = 1'b0;
    io.data = 16'h0;
    repeat (2) step(1, 0, 0, 16'h0);
    step(0, 0, 1, 16'h12AF);
    repeat (45) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h5555);
    repeat (45) step(0, 1, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    repeat (12) step(0, 1, 0, 16'h0);
    repeat (3) step(0, 0, 0, 16'h0);
    repeat (30) step(0, 1, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    repeat (5) step(0, 1, 0, 16'h0);
    step(1, 1, 1, 16'hFFFF);
    repeat (25) step(0, 1, 0, 16'h0);
    step(0, 0, 1, 16'h0007);
    repeat (25) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h0000);
    repeat (25) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h0A30);
    repeat (25) step(0, 1, 0, 16'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(49) == 0, $urandom_range(9) != 0, $urandom_range(7) == 0, 16'($urandom));
    repeat (2) @(negedge clk);
    #1;
    nchk++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
